// File: rtl/intdiv_signed_seq_div.sv
// Sequential signed divider: magnitude extraction, N-step restoring division,
// then sign reconversion. Quotient truncates toward zero; remainder follows dividend.
module intdiv_signed_seq_div #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] z,
  output logic [N-1:0] r,
  output logic         dbz
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic           r_sx;
  logic           r_sy;
  logic [N-1:0]   r_x;
  logic [N-1:0]   r_ay;
  logic [N-1:0]   r_rem;
  logic [N-1:0]   r_q;
  logic [N-1:0]   w_ax;
  logic [N-1:0]   w_ay;
  logic [N:0]     w_trial;
  logic [N:0]     w_diff;
  logic           w_busy_nxt;
  logic           w_done_nxt;

  // State register plus registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_next;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // busy covers CALC through DONE, so a start can never coincide with done
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_busy_nxt = (w_next != S_IDLE);
    w_done_nxt = (w_next == S_DONE);
  end

  // -2^(N-1) maps onto 2^(N-1) because the magnitudes are read as unsigned
  assign w_ax    = x[N-1] ? -x : x;
  assign w_ay    = y[N-1] ? -y : y;
  assign w_trial = {r_rem, r_q[N-1]};
  assign w_diff  = w_trial - {1'b0, r_ay};

  // r_q holds the unconsumed dividend bits and collects quotient bits from the LSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_sx  <= 1'b0;
      r_sy  <= 1'b0;
      r_x   <= '0;
      r_ay  <= '0;
      r_rem <= '0;
      r_q   <= '0;
      z     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x   <= x;
            r_sx  <= x[N-1];
            r_sy  <= y[N-1];
            r_q   <= w_ax;
            r_ay  <= w_ay;
            r_rem <= '0;
            r_cnt <= CW'(N - 1);
          end
        end
        S_CALC: begin
          if (!w_diff[N]) r_rem <= w_diff[N-1:0];
          else            r_rem <= w_trial[N-1:0];
          r_q   <= {r_q[N-2:0], ~w_diff[N]};
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          if (r_ay == '0) begin
            dbz <= 1'b1;
            z   <= '1;
            r   <= r_x;
          end else begin
            dbz <= 1'b0;
            z   <= (r_sx ^ r_sy) ? -r_q : r_q;
            r   <= r_sx ? -r_rem : r_rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intdiv_signed_seq_div.sv
// Directed bench for the signed sequential divider: N=5 arithmetic vectors
// and N=32 handshake, latency, busy-start rejection and mid-operation reset.
module tb_intdiv_signed_seq_div;

  logic        clk = 1'b0;
  logic        rst5, rst32;
  logic        start5, start32;
  logic [4:0]  x5, y5, z5, r5;
  logic [31:0] x32, y32, z32, r32;
  logic        busy5, done5, dbz5, busy32, done32, dbz32;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt32 = 0;
  int          cnt;

  always #5 clk = ~clk;

  intdiv_signed_seq_div #(.N(5)) u_div5 (
    .clk(clk), .rst(rst5), .start(start5), .x(x5), .y(y5),
    .busy(busy5), .done(done5), .z(z5), .r(r5), .dbz(dbz5)
  );

  intdiv_signed_seq_div #(.N(32)) u_div32 (
    .clk(clk), .rst(rst32), .start(start32), .x(x32), .y(y32),
    .busy(busy32), .done(done32), .z(z32), .r(r32), .dbz(dbz32)
  );

  always @(negedge clk) if (done32) done_cnt32++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one N=5 division and check latency plus results
  task automatic run5(input string tag, input logic [4:0] xv, input logic [4:0] yv,
                      input logic [4:0] ez, input logic [4:0] er, input logic edbz);
    int c;
    @(negedge clk);
    x5 = xv; y5 = yv; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    c = 1;
    while (!done5 && c < 30) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_lat"}, 32'(c), 32'd7);
    chk({tag, "_z"}, {27'd0, z5}, {27'd0, ez});
    chk({tag, "_r"}, {27'd0, r5}, {27'd0, er});
    chk({tag, "_dbz"}, {31'd0, dbz5}, {31'd0, edbz});
  endtask

  initial begin
    rst5 = 1'b1; rst32 = 1'b1;
    start5 = 1'b0; start32 = 1'b0;
    x5 = '0; y5 = '0; x32 = '0; y32 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {30'd0, busy5, busy32}, 32'd0);
    chk("rst_done", {30'd0, done5, done32}, 32'd0);
    chk("rst_z32", z32, 32'd0);
    chk("rst_r5", {27'd0, r5}, 32'd0);
    rst5 = 1'b0; rst32 = 1'b0;

    run5("p7_3",   5'd7,     5'd3,     5'd2,     5'd1,     1'b0);
    run5("p14_5",  5'd14,    5'd5,     5'd2,     5'd4,     1'b0);
    run5("p3_14",  5'd3,     5'd14,    5'd0,     5'd3,     1'b0);
    run5("p15_15", 5'd15,    5'd15,    5'd1,     5'd0,     1'b0);
    run5("p0_15",  5'd0,     5'd15,    5'd0,     5'd0,     1'b0);
    run5("nx5_3",  5'b11011, 5'b00011, 5'b11111, 5'b11110, 1'b0);
    run5("nx1_1",  5'b11111, 5'b00001, 5'b11111, 5'b00000, 1'b0);
    run5("ny1_15", 5'b00001, 5'b10001, 5'b00000, 5'b00001, 1'b0);
    run5("ny5_15", 5'b00101, 5'b10001, 5'b00000, 5'b00101, 1'b0);
    run5("nn7_4",  5'b11001, 5'b11100, 5'b00001, 5'b11101, 1'b0);
    run5("nn11_15",5'b10101, 5'b10001, 5'b00000, 5'b10101, 1'b0);
    run5("dbz",    5'b01111, 5'b00000, 5'b11111, 5'b01111, 1'b1);
    run5("ovf",    5'b10000, 5'b11111, 5'b10000, 5'b00000, 1'b0);
    run5("after_dbz", 5'd9,  5'd2,     5'd4,     5'd1,     1'b0);

    // N=32 latency and start rejection while busy
    @(negedge clk);
    x32 = 32'd100; y32 = 32'd7; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    chk("t32_busy_rise", {31'd0, busy32}, 32'd1);
    cnt = 1;
    while (!done32 && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (cnt == 5 || cnt == 20) begin
        start32 = 1'b1; x32 = 32'd5; y32 = 32'd1;
      end else begin
        start32 = 1'b0;
      end
    end
    chk("t32_lat", 32'(cnt), 32'd34);
    chk("t32_z", z32, 32'd14);
    chk("t32_r", r32, 32'd2);
    chk("t32_busy_at_done", {31'd0, busy32}, 32'd1);
    start32 = 1'b1; x32 = 32'd5; y32 = 32'd1;
    @(negedge clk);
    start32 = 1'b0;
    chk("t32_done_one_cycle", {31'd0, done32}, 32'd0);
    chk("t32_busy_fall", {31'd0, busy32}, 32'd0);
    repeat (40) @(negedge clk);
    chk("t32_no_extra_done", 32'(done_cnt32), 32'd1);
    chk("t32_hold_z", z32, 32'd14);

    // Reset mid-CALC aborts with no done pulse
    @(negedge clk);
    x32 = 32'd100; y32 = 32'd7; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_busy_pre", {31'd0, busy32}, 32'd1);
    rst32 = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy32}, 32'd0);
    chk("abort_z", z32, 32'd0);
    chk("abort_r", r32, 32'd0);
    @(negedge clk);
    rst32 = 1'b0;
    repeat (45) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt32), 32'd1);
    chk("abort_idle", {31'd0, busy32}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
